binario_a_bcd_seq: RTL and testbench
====================================

// Module: binario_a_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
//   Feeds decodificador_bcd: each 4-bit digit of bcd drives one decoder
//   instance and one 7-segment display.
//   Start/done handshake; the result is held stable between conversions.
// PARAMETERS
//   WIDTH   8  bit width of the binary input (>=1)
//   DIGITS  3  number of BCD digits produced (>=1)
// PORTS
//   clk       in   1           rising-edge clock
//   rst       in   1           synchronous reset, active-high
//   start     in   1           request conversion of bin; sampled only in IDLE
//   bin       in   WIDTH       unsigned value; captured at the accepted start edge
//   busy      out  1           conversion in progress
//   done      out  1           one-cycle pulse; bcd/overflow updated this cycle
//   bcd       out  4*DIGITS    result; digit i = bcd[4i+3:4i], digit 0 = units
//   overflow  out  1           bin > 10^DIGITS-1; bcd is then the low DIGITS digits
// BEHAVIOUR
//   Reset: busy=0, done=0, bcd=0, overflow=0, FSM=IDLE, internal regs cleared.
//   FSM states: IDLE, SHIFT.
//   - IDLE: start=1 at edge N -> capture bin into shift reg, clear scratch BCD
//     and sticky ovf, load cnt=WIDTH, busy=1, go SHIFT.
//   - SHIFT, one step per edge: for every scratch digit >=5 add 3 (4-bit, no
//     carry between digits), then shift {scratch,shreg} left 1. A 1 shifted
//     out of scratch MSB sets sticky ovf. cnt decrements each step.
//   - Edge applying the final step (N+WIDTH): bcd <= post-step scratch,
//     overflow <= sticky ovf including that step, done=1, busy=0, go IDLE.
//   Latency: start sampled at edge N -> done high for cycle after edge N+WIDTH.
//   done is exactly one cycle; bcd and overflow are unchanged until next done.
//   start during SHIFT is ignored (not queued). start while done=1 is accepted
//   (FSM already IDLE): back-to-back throughput = one result per WIDTH cycles.
//   bin changes after the accepted start edge do not affect the result.
//   rst mid-conversion: aborts; all outputs return to reset values next cycle.
//   Width rules: scratch is 4*DIGITS bits; digits never exceed 9 after an
//   add-3 step. If WIDTH <= 3, no adjust ever fires and the result is bin.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: extra output port
//     blank  out  DIGITS  bit i=1 when digits i..DIGITS-1 of bcd are all 0,
//     i>=1; blank[0] is always 0 (units digit always shown). Registered and
//     updated with bcd on done; reset value {DIGITS-1{1'b1},1'b0}.
//     Intended to gate the display enable next to decodificador_bcd.
//   Not defined: blank port and its logic are absent; other behaviour identical.
// TESTING
//   1 reset, start=1 bin=8'd255 -> done after 8 cycles, bcd=12'h255, ovf=0, busy=0
//   2 bin=0 -> bcd=12'h000, done pulse 1 cycle; bin=8'd99 -> bcd=12'h099
//   3 start bin=8'd1, pulse start bin=8'd200 at cycle 3 -> single done, bcd=12'h001
//   4 start bin=8'd128, rst at cycle 4 -> busy=0 done=0 bcd=0; no done follows
//   5 WIDTH=10 DIGITS=3: bin=10'd1000 -> bcd=12'h000, ovf=1; bin=999 -> 12'h999, ovf=0
//   6 LEADING_ZERO_BLANK_EN: bin=7 -> blank=3'b110; bin=40 -> 3'b100; 0 -> 3'b110
//   Every test: start asserted in the same cycle as done is accepted; no lost result.

Source files
------------

// File: rtl/binario_a_bcd_seq_if.sv
// Start/done bus of the sequential binary-to-BCD converter.
// LEADING_ZERO_BLANK_EN adds the per-digit blank vector to the bus.
interface binario_a_bcd_seq_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [WIDTH-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  overflow;
`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0]     blank;

   modport master (output start, bin, input busy, done, bcd, overflow, blank);
   modport slave  (input start, bin, output busy, done, bcd, overflow, blank);
`else
   modport master (output start, bin, input busy, done, bcd, overflow);
   modport slave  (input start, bin, output busy, done, bcd, overflow);
`endif
endinterface

// File: rtl/binario_a_bcd_seq.sv
// Shift-add-3 binary-to-BCD converter, one bit per clock, start/done handshake.
// LEADING_ZERO_BLANK_EN adds a registered leading-zero blank vector for the displays.
module binario_a_bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst,
   binario_a_bcd_seq_if.slave  bus
);
   localparam int SW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] shreg;
   logic [SW-1:0]    scratch;
   logic [CW-1:0]    cnt;
   logic             ovf_sticky;
   logic             busy_r;
   logic             done_r;
   logic [SW-1:0]    bcd_r;
   logic             ovf_r;

   logic [SW-1:0]    adjusted;
   logic [SW-1:0]    next_scratch;
   logic             ovf_next;

   // Digits are adjusted independently; a carry out of the top digit is the overflow.
   always_comb begin
      adjusted = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
      next_scratch = {adjusted[SW-2:0], shreg[WIDTH-1]};
      ovf_next     = ovf_sticky | adjusted[SW-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         scratch    <= '0;
         cnt        <= '0;
         ovf_sticky <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         bcd_r      <= '0;
         ovf_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  shreg      <= bus.bin;
                  scratch    <= '0;
                  ovf_sticky <= 1'b0;
                  cnt        <= CW'(WIDTH);
                  busy_r     <= 1'b1;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               scratch    <= next_scratch;
               shreg      <= shreg << 1;
               ovf_sticky <= ovf_next;
               cnt        <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  bcd_r  <= next_scratch;
                  ovf_r  <= ovf_next;
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.bcd      = bcd_r;
   assign bus.overflow = ovf_r;

`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_r;
   logic [DIGITS-1:0] blank_nxt;
   logic              zero_acc;

   // Scan from the most significant digit; the units digit is never blanked.
   always_comb begin
      blank_nxt = '0;
      zero_acc  = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_acc     = zero_acc & (next_scratch[4*i +: 4] == 4'd0);
         blank_nxt[i] = (i != 0) ? zero_acc : 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         blank_r <= {DIGITS{1'b1}} << 1;
      else if (state == SHIFT && cnt == CW'(1))
         blank_r <= blank_nxt;
   end

   assign bus.blank = blank_r;
`endif
endmodule

// File: tb/tb_binario_a_bcd_seq.sv
// Scoreboard bench for binario_a_bcd_seq: an 8-bit and a 10-bit instance, 3 digits each.
module tb_binario_a_bcd_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   binario_a_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) b8();
   binario_a_bcd_seq_if #(.WIDTH(10), .DIGITS(3)) b10();

   binario_a_bcd_seq #(.WIDTH(8),  .DIGITS(3)) dut8  (.clk(clk), .rst(rst), .bus(b8));
   binario_a_bcd_seq #(.WIDTH(10), .DIGITS(3)) dut10 (.clk(clk), .rst(rst), .bus(b10));

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [12:0] sb_q[$];

   // Decimal reference: {overflow, low three BCD digits}.
   function automatic logic [12:0] model(input int v);
      int r;
      logic [11:0] b;
      r = v % 1000;
      b[3:0]  = 4'(r % 10);
      b[7:4]  = 4'((r / 10) % 10);
      b[11:8] = 4'(r / 100);
      return {(v > 999), b};
   endfunction

   // Launch a conversion on the 8-bit unit and wait for done (bounded).
   task automatic run8(input int v, output int lat);
      b8.start = 1'b1;
      b8.bin   = 8'(v);
      sb_q.push_back(model(v));
      @(negedge clk);
      b8.start = 1'b0;
      b8.bin   = 8'($urandom);
      lat = 0;
      while (!b8.done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run10(input int v, output int lat);
      b10.start = 1'b1;
      b10.bin   = 10'(v);
      sb_q.push_back(model(v));
      @(negedge clk);
      b10.start = 1'b0;
      b10.bin   = 10'($urandom);
      lat = 0;
      while (!b10.done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total_cnt += 8;
      if (b8.busy !== 1'b0) $display("FAIL reset_busy8 got=%b exp=0", b8.busy); else pass_cnt++;
      if (b8.done !== 1'b0) $display("FAIL reset_done8 got=%b exp=0", b8.done); else pass_cnt++;
      if (b8.bcd !== 12'h000) $display("FAIL reset_bcd8 got=%h exp=000", b8.bcd); else pass_cnt++;
      if (b8.overflow !== 1'b0) $display("FAIL reset_ovf8 got=%b exp=0", b8.overflow); else pass_cnt++;
      if (b10.busy !== 1'b0) $display("FAIL reset_busy10 got=%b exp=0", b10.busy); else pass_cnt++;
      if (b10.done !== 1'b0) $display("FAIL reset_done10 got=%b exp=0", b10.done); else pass_cnt++;
      if (b10.bcd !== 12'h000) $display("FAIL reset_bcd10 got=%h exp=000", b10.bcd); else pass_cnt++;
      if (b10.overflow !== 1'b0) $display("FAIL reset_ovf10 got=%b exp=0", b10.overflow); else pass_cnt++;
`ifdef LEADING_ZERO_BLANK_EN
      total_cnt++;
      if (b8.blank !== 3'b110) $display("FAIL reset_blank got=%b exp=110", b8.blank); else pass_cnt++;
`endif
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int lat;
      logic [12:0] exp;
      b8.start = 1'b1;
      b8.bin   = 8'd255;
      sb_q.push_back(model(255));
      @(negedge clk);
      b8.start = 1'b0;
      total_cnt++;
      if (b8.busy !== 1'b1) $display("FAIL basic_busy got=%b exp=1", b8.busy); else pass_cnt++;
      lat = 0;
      while (!b8.done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      exp = sb_q.pop_front();
      total_cnt += 4;
      if (lat !== 8) $display("FAIL basic_latency got=%0d exp=8", lat); else pass_cnt++;
      if (b8.bcd !== exp[11:0]) $display("FAIL basic_bcd got=%h exp=%h", b8.bcd, exp[11:0]); else pass_cnt++;
      if (b8.overflow !== exp[12]) $display("FAIL basic_ovf got=%b exp=%b", b8.overflow, exp[12]); else pass_cnt++;
      if (b8.busy !== 1'b0) $display("FAIL basic_busy_done got=%b exp=0", b8.busy); else pass_cnt++;
      @(negedge clk);
      total_cnt += 2;
      if (b8.done !== 1'b0) $display("FAIL basic_done_pulse got=%b exp=0", b8.done); else pass_cnt++;
      if (b8.bcd !== 12'h255) $display("FAIL basic_bcd_hold got=%h exp=255", b8.bcd); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [12:0] exp;
      int vals[4] = '{0, 99, 9, 100};
      foreach (vals[k]) begin
         run8(vals[k], lat);
         exp = sb_q.pop_front();
         total_cnt += 3;
         if (lat !== 8) $display("FAIL b2b_latency[%0d] got=%0d exp=8", k, lat); else pass_cnt++;
         if (b8.bcd !== exp[11:0]) $display("FAIL b2b_bcd[%0d] got=%h exp=%h", k, b8.bcd, exp[11:0]); else pass_cnt++;
         if (b8.overflow !== exp[12]) $display("FAIL b2b_ovf[%0d] got=%b exp=%b", k, b8.overflow, exp[12]); else pass_cnt++;
      end
      for (int k = 0; k < 6; k++) begin
         run8(int'($urandom_range(0, 255)), lat);
         exp = sb_q.pop_front();
         total_cnt += 2;
         if (lat !== 8) $display("FAIL rnd_latency[%0d] got=%0d exp=8", k, lat); else pass_cnt++;
         if ({b8.overflow, b8.bcd} !== exp) $display("FAIL rnd_result[%0d] got=%h exp=%h", k, {b8.overflow, b8.bcd}, exp); else pass_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic test_start_ignored;
      int dones;
      logic [11:0] got;
      logic [12:0] exp;
      b8.start = 1'b1;
      b8.bin   = 8'd1;
      sb_q.push_back(model(1));
      @(negedge clk);
      b8.start = 1'b0;
      repeat (2) @(negedge clk);
      b8.start = 1'b1;
      b8.bin   = 8'd200;
      @(negedge clk);
      b8.start = 1'b0;
      dones = 0;
      got   = '0;
      for (int c = 0; c < 20; c++) begin
         if (b8.done) begin
            dones++;
            got = b8.bcd;
         end
         @(negedge clk);
      end
      exp = sb_q.pop_front();
      total_cnt += 2;
      if (dones !== 1) $display("FAIL ignored_done_count got=%0d exp=1", dones); else pass_cnt++;
      if (got !== exp[11:0]) $display("FAIL ignored_bcd got=%h exp=%h", got, exp[11:0]); else pass_cnt++;
   endtask

   task automatic test_abort;
      int dones;
      b8.start = 1'b1;
      b8.bin   = 8'd128;
      @(negedge clk);
      b8.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total_cnt += 4;
      if (b8.busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", b8.busy); else pass_cnt++;
      if (b8.done !== 1'b0) $display("FAIL abort_done got=%b exp=0", b8.done); else pass_cnt++;
      if (b8.bcd !== 12'h000) $display("FAIL abort_bcd got=%h exp=000", b8.bcd); else pass_cnt++;
      if (b8.overflow !== 1'b0) $display("FAIL abort_ovf got=%b exp=0", b8.overflow); else pass_cnt++;
      dones = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (b8.done) dones++;
      end
      total_cnt++;
      if (dones !== 0) $display("FAIL abort_no_done got=%0d exp=0", dones); else pass_cnt++;
   endtask

   task automatic test_wide;
      int lat;
      logic [12:0] exp;
      int vals[4] = '{1000, 999, 1023, 512};
      foreach (vals[k]) begin
         run10(vals[k], lat);
         exp = sb_q.pop_front();
         total_cnt += 3;
         if (lat !== 10) $display("FAIL wide_latency[%0d] got=%0d exp=10", k, lat); else pass_cnt++;
         if (b10.bcd !== exp[11:0]) $display("FAIL wide_bcd[%0d] got=%h exp=%h", k, b10.bcd, exp[11:0]); else pass_cnt++;
         if (b10.overflow !== exp[12]) $display("FAIL wide_ovf[%0d] got=%b exp=%b", k, b10.overflow, exp[12]); else pass_cnt++;
      end
      @(negedge clk);
   endtask

`ifdef LEADING_ZERO_BLANK_EN
   task automatic test_blank;
      int lat;
      logic [12:0] exp;
      int vals[4]        = '{7, 40, 0, 205};
      logic [2:0] bl[4]  = '{3'b110, 3'b100, 3'b110, 3'b000};
      foreach (vals[k]) begin
         run8(vals[k], lat);
         exp = sb_q.pop_front();
         total_cnt += 2;
         if (b8.bcd !== exp[11:0]) $display("FAIL blank_bcd[%0d] got=%h exp=%h", k, b8.bcd, exp[11:0]); else pass_cnt++;
         if (b8.blank !== bl[k]) $display("FAIL blank[%0d] got=%b exp=%b", k, b8.blank, bl[k]); else pass_cnt++;
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      b8.start  = 1'b0;
      b8.bin    = '0;
      b10.start = 1'b0;
      b10.bin   = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_start_ignored();
      test_abort();
      test_wide();
`ifdef LEADING_ZERO_BLANK_EN
      test_blank();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
